// File: rtl/mips_pkg.sv
// Shared MIPS instruction constants and a field-level encoder.
// The decode stage imports the same definitions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] KIND_RTYPE   = 2'b00;
  localparam logic [1:0] KIND_LW      = 2'b01;
  localparam logic [1:0] KIND_SW      = 2'b10;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } enc_state_e;

  // Fields a kind does not use are ignored; an illegal kind yields zero.
  function automatic logic [31:0] encode_instr(input logic [1:0]  kind,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd,
                                               input logic [5:0]  funct,
                                               input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    case (kind)
      KIND_RTYPE: begin
        w[OPCODE_LSB +: 6] = OP_RTYPE;
        w[RD_LSB +: 5]     = rd;
        w[SHAMT_LSB +: 5]  = 5'b00000;
        w[FUNCT_LSB +: 6]  = funct;
      end
      KIND_LW: begin
        w[OPCODE_LSB +: 6] = OP_LW;
        w[IMM_LSB +: 16]   = imm;
      end
      KIND_SW: begin
        w[OPCODE_LSB +: 6] = OP_SW;
        w[IMM_LSB +: 16]   = imm;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instruction_encode_if.sv
// Request and instruction-memory write buses of the encoder.
// master is the encoder side, slave is the loader / memory side.
interface instruction_encode_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO; DEPTH must be a power of two >= 2.
// rdata reads as zero while empty; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_encode.sv
// Packs field-level requests into MIPS words, queues them and writes them
// to instruction memory at consecutive word addresses starting at base_addr.
module instruction_encode
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  instruction_encode_if.master bus,
  output logic                done,
  output logic                err
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0]       fifo_rdata, enc_word;
  logic              in_ready, accept, kind_legal, start_ok;

  assign enc_word = encode_instr(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                                 bus.in_funct, bus.in_imm);
  assign kind_legal = (bus.in_kind != KIND_ILLEGAL);
  assign start_ok   = (state_q == StIdle) && start;
  assign accept     = bus.in_valid && in_ready;
  // Illegal requests complete the handshake but never occupy a slot or an address.
  assign fifo_push  = accept && kind_legal;
  assign fifo_pop   = !fifo_empty && bus.out_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        in_ready = !fifo_full;
        if (bus.in_valid && !fifo_full && bus.in_last) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    if (start_ok) begin
      addr_d = base_addr;
      err_d  = 1'b0;
    end else begin
      // Counter wraps silently at 2^ADDR_W.
      if (fifo_pop) addr_d = addr_q + 1'b1;
      if (accept && !kind_legal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_rdata;
  assign bus.out_addr  = addr_q;
  assign err           = err_q;

endmodule
